timer_alarm_sequencer: RTL

Avalon-MM master that configures and services the interval timer peripheral: programs its period, starts it in continuous/interrupt mode, and clears each timeout. Each serviced timeout is one tick of an hours/minutes/seconds time-of-day counter, which is compared against a programmable alarm time. Sits between the timer slave port and the alarm front-end (display, buttons, buzzer), replacing the software driver loop.

---
 rtl/timer_alarm_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/timer_alarm_sequencer.sv
// Avalon-MM master for the interval timer plus an hh:mm:ss clock with alarm.
// Define SNOOZE_EN to add the snooze port and snooze target register.
module timer_alarm_sequencer #(
  parameter logic [31:0] PERIOD = 32'd49_999_999
`ifdef SNOOZE_EN
  ,
  parameter int SNOOZE_MIN = 5
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic        timer_irq,
  input  logic        enable,
  input  logic        set_time,
  input  logic [4:0]  set_h,
  input  logic [5:0]  set_m,
  input  logic        alarm_en,
  input  logic [4:0]  alarm_h,
  input  logic [5:0]  alarm_m,
  input  logic        alarm_ack,
`ifdef SNOOZE_EN
  input  logic        snooze,
`endif
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic        alarm,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, STOP
  } state_t;

  state_t      r_state;
  logic [2:0]  r_address;
  logic        r_chipselect;
  logic        r_writeN;
  logic [15:0] r_writedata;
  logic        r_busy;
  logic [4:0]  r_hours;
  logic [5:0]  r_minutes;
  logic [5:0]  r_seconds;
  logic        r_alarm;

  logic        w_tick;
  logic        w_setOk;
  logic        w_tickMatch;
  logic        w_setMatch;
  logic [4:0]  w_nextH;
  logic [5:0]  w_nextM;
  logic [5:0]  w_nextS;

  assign m_address    = r_address;
  assign m_chipselect = r_chipselect;
  assign m_write_n    = r_writeN;
  assign m_writedata  = r_writedata;
  assign busy         = r_busy;
  assign hours        = r_hours;
  assign minutes      = r_minutes;
  assign seconds      = r_seconds;
  assign alarm        = r_alarm;

  // Bus outputs describe the state being entered, so each write lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_address    <= 3'd0;
      r_chipselect <= 1'b0;
      r_writeN     <= 1'b1;
      r_writedata  <= 16'd0;
      r_busy       <= 1'b0;
    end else begin
      r_address    <= 3'd0;
      r_chipselect <= 1'b0;
      r_writeN     <= 1'b1;
      r_writedata  <= 16'd0;
      r_busy       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state      <= WR_PL;
            r_address    <= 3'd2;
            r_chipselect <= 1'b1;
            r_writeN     <= 1'b0;
            r_writedata  <= PERIOD[15:0];
            r_busy       <= 1'b1;
          end
        end
        WR_PL: begin
          r_state      <= WR_PH;
          r_address    <= 3'd3;
          r_chipselect <= 1'b1;
          r_writeN     <= 1'b0;
          r_writedata  <= PERIOD[31:16];
          r_busy       <= 1'b1;
        end
        WR_PH: begin
          r_state      <= WR_CTRL;
          r_address    <= 3'd1;
          r_chipselect <= 1'b1;
          r_writeN     <= 1'b0;
          r_writedata  <= 16'h0007;
          r_busy       <= 1'b1;
        end
        WR_CTRL: r_state <= RUN;
        RUN: begin
          if (timer_irq) begin
            r_state      <= CLR;
            r_address    <= 3'd0;
            r_chipselect <= 1'b1;
            r_writeN     <= 1'b0;
            r_writedata  <= 16'h0000;
            r_busy       <= 1'b1;
          end else if (!enable) begin
            r_state      <= STOP;
            r_address    <= 3'd1;
            r_chipselect <= 1'b1;
            r_writeN     <= 1'b0;
            r_writedata  <= 16'h0008;
            r_busy       <= 1'b1;
          end
        end
        CLR:     r_state <= RUN;
        STOP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The tick lands on the edge entering CLR, so the new time shows during the clear write.
  always_comb begin
    w_tick  = (r_state == RUN) && timer_irq;
    w_setOk = set_time && (set_h <= 5'd23) && (set_m <= 6'd59);
    w_nextH = r_hours;
    w_nextM = r_minutes;
    w_nextS = r_seconds + 6'd1;
    if (r_seconds == 6'd59) begin
      w_nextS = 6'd0;
      w_nextM = r_minutes + 6'd1;
      if (r_minutes == 6'd59) begin
        w_nextM = 6'd0;
        w_nextH = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
      end
    end
    w_tickMatch = w_tick && !w_setOk && alarm_en && (w_nextH == alarm_h) &&
                  (w_nextM == alarm_m) && (w_nextS == 6'd0);
    w_setMatch  = w_setOk && alarm_en && (set_h == alarm_h) && (set_m == alarm_m);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hours   <= 5'd0;
      r_minutes <= 6'd0;
      r_seconds <= 6'd0;
    end else if (w_setOk) begin
      r_hours   <= set_h;
      r_minutes <= set_m;
      r_seconds <= 6'd0;
    end else if (w_tick) begin
      r_hours   <= w_nextH;
      r_minutes <= w_nextM;
      r_seconds <= w_nextS;
    end
  end

`ifdef SNOOZE_EN
  logic [6:0] w_snzSum;
  logic [5:0] w_snzM;
  logic [4:0] w_snzH;
  logic       w_snzMatch;
  logic       r_snzValid;
  logic [4:0] r_snzH;
  logic [5:0] r_snzM;

  always_comb begin
    w_snzSum = {1'b0, r_minutes} + 7'(SNOOZE_MIN);
    w_snzM   = w_snzSum[5:0];
    w_snzH   = r_hours;
    if (w_snzSum >= 7'd60) begin
      w_snzM = 6'(w_snzSum - 7'd60);
      w_snzH = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
    end
    w_snzMatch = r_snzValid && w_tick && !w_setOk && (w_nextH == r_snzH) &&
                 (w_nextM == r_snzM) && (w_nextS == 6'd0);
  end
`endif

  // Later assignments win: a fresh match always beats an ack or snooze in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alarm <= 1'b0;
`ifdef SNOOZE_EN
      r_snzValid <= 1'b0;
      r_snzH     <= 5'd0;
      r_snzM     <= 6'd0;
`endif
    end else begin
      if (alarm_ack) r_alarm <= 1'b0;
`ifdef SNOOZE_EN
      if (snooze && r_alarm) begin
        r_alarm    <= 1'b0;
        r_snzValid <= 1'b1;
        r_snzH     <= w_snzH;
        r_snzM     <= w_snzM;
      end
      if (alarm_ack || w_setOk || w_snzMatch) r_snzValid <= 1'b0;
      if (w_snzMatch) r_alarm <= 1'b1;
`endif
      if (w_tickMatch || w_setMatch) r_alarm <= 1'b1;
    end
  end

endmodule
